multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 80 ++++++++
 tb/tb_multdiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply/divide, 32 iterations, registered result
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q, acc_d, x_q, x_d, prod;
  logic [31:0] y_q, y_d, mag_a, mag_b, quot;
  logic [32:0] t;
  logic        neg_q, dz_q, ov_q, start, ge, mul_exc;
  // One shift-add (MUL) or restoring-divide (DIV) step on operand magnitudes
  always_comb begin
    mag_a   = data_operandA[31] ? -data_operandA : data_operandA;
    mag_b   = data_operandB[31] ? -data_operandB : data_operandB;
    start   = (state_q == IDLE || state_q == DONE) && (ctrl_MULT || ctrl_DIV);
    t       = {acc_q[31:0], y_q[31]};
    ge      = t >= {1'b0, x_q[31:0]};
    acc_d   = state_q == MUL ? acc_q + (y_q[0] ? x_q : 64'd0)
                             : {31'd0, ge ? t - {1'b0, x_q[31:0]} : t};
    x_d     = state_q == MUL ? x_q << 1 : x_q;
    y_d     = state_q == MUL ? y_q >> 1 : {y_q[30:0], ge};
    prod    = neg_q ? -acc_d : acc_d;
    quot    = neg_q ? -y_d : y_d;
    mul_exc = !(&prod[63:31] || !(|prod[63:31]));
  end
  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      neg_q          <= 1'b0;
      dz_q           <= 1'b0;
      ov_q           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state_q <= ctrl_MULT ? MUL : DIV;
        cnt_q   <= '0;
        busy    <= 1'b1;
        neg_q   <= data_operandA[31] ^ data_operandB[31];
        dz_q    <= !ctrl_MULT && data_operandB == 32'd0;
        ov_q    <= !ctrl_MULT && data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
        acc_q   <= '0;
        x_q     <= {32'd0, ctrl_MULT ? mag_a : mag_b};
        y_q     <= ctrl_MULT ? mag_b : mag_a;
      end else if (state_q == MUL || state_q == DIV) begin
        acc_q <= acc_d;
        x_q   <= x_d;
        y_q   <= y_d;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_q        <= DONE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          data_result    <= state_q == MUL ? prod[31:0] : (dz_q ? 32'd0 : quot);
          data_exception <= state_q == MUL ? mul_exc : (dz_q || ov_q);
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed tests plus a cycle-level reference model of multdiv_unit
module tb_multdiv_unit;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic        data_exception, data_resultRDY, busy;
  int          checks = 0, passes = 0;
  logic        en = 1'b0;

  multdiv_unit dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Arithmetic reference: {exception, result}
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic m);
    longint p;
    int     q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p > 64'sd2147483647 || p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = int'($signed(a)) / int'($signed(b));
    return {1'b0, q};
  endfunction

  // Protocol model: accept a start whenever not iterating, ready 32 edges later
  logic        m_busy = 1'b0, m_rdy = 1'b0, m_exc = 1'b0;
  logic [31:0] m_res = '0;
  logic [32:0] m_pend = '0;
  int          m_left = 0;
  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0; m_rdy <= 1'b0; m_res <= '0; m_exc <= 1'b0; m_left <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_rdy <= 1'b1; m_res <= m_pend[31:0]; m_exc <= m_pend[32];
        end
      end else if (ctrl_MULT || ctrl_DIV) begin
        m_pend <= ref_op(data_operandA, data_operandB, ctrl_MULT);
        m_busy <= 1'b1;
        m_left <= 32;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
      chk("cyc_result", data_result, m_res);
      chk("cyc_exc", {31'd0, data_exception}, {31'd0, m_exc});
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
    data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  // Called at the n0-th negedge after the capture edge; ready expected at the 33rd
  task automatic wait_rdy(input string nm, input int n0, input logic [31:0] er, input logic ee);
    int n = n0;
    int bc = busy ? 1 : 0;
    while (!data_resultRDY && n < 40) begin
      @(negedge clock);
      n++;
      if (!data_resultRDY && busy) bc++;
    end
    chk({nm, "_latency"}, n - 1, 32);
    chk({nm, "_busy_cycles"}, bc, 33 - n0);
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    en = 1'b1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("ref_mul", ref_op(32'd7, 32'hFFFF_FFFA, 1'b1), {1'b0, 32'hFFFF_FFD6});
    chk("ref_div", ref_op(32'hFFFF_FF9C, 32'd7, 1'b0), {1'b0, 32'hFFFF_FFF2});
    start_op(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0);
    wait_rdy("mul_7x-6", 1, 32'hFFFF_FFD6, 1'b0);
    @(negedge clock);
    chk("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    chk("result_holds", data_result, 32'hFFFF_FFD6);
    start_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    wait_rdy("mul_ovf", 1, 32'd0, 1'b1);
    start_op(32'hFFFF_8000, 32'h0001_0000, 1'b1, 1'b0);
    wait_rdy("mul_min_fit", 1, 32'h8000_0000, 1'b0);
    start_op(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
    wait_rdy("div_-100/7", 1, 32'hFFFF_FFF2, 1'b0);
    start_op(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1);
    wait_rdy("div_100/-7", 1, 32'hFFFF_FFF2, 1'b0);
    start_op(32'd5, 32'd0, 1'b0, 1'b1);
    wait_rdy("div_by_zero", 1, 32'd0, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_rdy("div_ovf", 1, 32'h8000_0000, 1'b1);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_rdy("div_-7/2", 1, 32'hFFFF_FFFD, 1'b0);
    start_op(32'd3, 32'd5, 1'b1, 1'b0);
    repeat (9) @(negedge clock);
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy("ignore_div", 11, 32'd15, 1'b0);
    start_op(32'd6, 32'd7, 1'b1, 1'b1);
    wait_rdy("mul_wins", 1, 32'd42, 1'b0);
    start_op(32'd2, 32'd3, 1'b1, 1'b0);
    wait_rdy("b2b_first", 1, 32'd6, 1'b0);
    start_op(32'd9, 32'hFFFF_FFFD, 1'b1, 1'b0);
    wait_rdy("b2b_second", 1, 32'hFFFF_FFE5, 1'b0);
    start_op(32'h0000_1234, 32'd16, 1'b1, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", data_result, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("abort_no_rdy", seen, 32'd0);
    start_op(32'd3, 32'd4, 1'b1, 1'b0);
    wait_rdy("post_reset_mul", 1, 32'd12, 1'b0);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
